// File: rtl/uart_rx_fpga_if.sv
// uart_rx_fpga_if
// Purpose : groups the serial RX pin and the received-byte status bundle of
//           the UART receiver so that the receiver and its consumer share one
//           port.
// Signals : i_dataRx      - serial RX line, idles high
//           o_bitsRx      - last received byte
//           o_doneRx      - one-cycle frame-complete strobe
//           o_parityErrRx - even-parity mismatch on the last frame
//           o_frameErrRx  - stop bit sampled low on the last frame
//           o_busyRx      - receiver is inside a frame (or a break)
// Modports: master - the receiver (drives the status, reads the pin)
//           slave  - the pin driver / byte consumer
interface uart_rx_fpga_if;
   logic       i_dataRx;
   logic [7:0] o_bitsRx;
   logic       o_doneRx;
   logic       o_parityErrRx;
   logic       o_frameErrRx;
   logic       o_busyRx;

   modport master (
      input  i_dataRx,
      output o_bitsRx,
      output o_doneRx,
      output o_parityErrRx,
      output o_frameErrRx,
      output o_busyRx
   );

   modport slave (
      output i_dataRx,
      input  o_bitsRx,
      input  o_doneRx,
      input  o_parityErrRx,
      input  o_frameErrRx,
      input  o_busyRx
   );
endinterface

// File: rtl/uart_rx_fpga.sv
// uart_rx_fpga
// Purpose : UART receiver for 8-data-bit, even-parity, one-stop-bit frames,
//           LSB first. Each frame ends with a one-cycle done strobe plus
//           parity-error and framing-error status, all held until the next
//           frame completes.
// Params  : clksPerBit - system clocks per UART bit (4..256)
// Ports   : i_clkRx - system clock, rising edge
//           i_reset - asynchronous active-high reset
//           rxIf    - uart_rx_fpga_if.master (pin in, byte/status out)
module uart_rx_fpga #(
   parameter int clksPerBit = 234
) (
   input  logic           i_clkRx,
   input  logic           i_reset,
   uart_rx_fpga_if.master rxIf
);

   localparam logic [7:0] lastCount = 8'(clksPerBit - 1);
   localparam logic [7:0] midCount  = 8'((clksPerBit - 1) / 2);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rxState_t;

   rxState_t   state;
   logic [7:0] bitCount;
   logic [2:0] bitIndex;
   logic [7:0] dataShift;
   logic       parityBad;
   logic       syncA;
   logic       rxS;
   logic [7:0] bitsReg;
   logic       doneReg;
   logic       parityErrReg;
   logic       frameErrReg;
   logic       busyReg;

   // Two-flop synchronizer for the asynchronous pin. Both flops reset high so
   // that reset release never looks like a start bit.
   always_ff @(posedge i_clkRx or posedge i_reset) begin
      if (i_reset) begin
         syncA <= 1'b1;
         rxS   <= 1'b1;
      end else begin
         syncA <= rxIf.i_dataRx;
         rxS   <= syncA;
      end
   end

   // Frame FSM. START validates the start bit at its middle, after which every
   // later sample lands one full bit period later, i.e. at mid-bit. The stop
   // sample publishes the byte and status on the same edge, so the done strobe
   // is visible in the cycle the FSM is back in IDLE (or in BREAK). busyReg is
   // updated together with every state change so it tracks state exactly.
   always_ff @(posedge i_clkRx or posedge i_reset) begin
      if (i_reset) begin
         state        <= IDLE;
         bitCount     <= 8'd0;
         bitIndex     <= 3'd0;
         dataShift    <= 8'd0;
         parityBad    <= 1'b0;
         bitsReg      <= 8'd0;
         doneReg      <= 1'b0;
         parityErrReg <= 1'b0;
         frameErrReg  <= 1'b0;
         busyReg      <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         case (state)
            IDLE: begin
               bitCount <= 8'd0;
               bitIndex <= 3'd0;
               if (!rxS) begin
                  state   <= START;
                  busyReg <= 1'b1;
               end
            end
            START: begin
               if (bitCount == midCount) begin
                  bitCount <= 8'd0;
                  if (!rxS) begin
                     state <= DATA;
                  end else begin
                     state   <= IDLE;
                     busyReg <= 1'b0;
                  end
               end else begin
                  bitCount <= bitCount + 8'd1;
               end
            end
            DATA: begin
               if (bitCount == lastCount) begin
                  bitCount            <= 8'd0;
                  dataShift[bitIndex] <= rxS;
                  bitIndex            <= bitIndex + 3'd1;
                  if (bitIndex == 3'd7) begin
                     state <= PARITY;
                  end
               end else begin
                  bitCount <= bitCount + 8'd1;
               end
            end
            PARITY: begin
               if (bitCount == lastCount) begin
                  bitCount  <= 8'd0;
                  parityBad <= rxS ^ (^dataShift);
                  state     <= STOP;
               end else begin
                  bitCount <= bitCount + 8'd1;
               end
            end
            STOP: begin
               if (bitCount == lastCount) begin
                  bitCount     <= 8'd0;
                  bitsReg      <= dataShift;
                  parityErrReg <= parityBad;
                  frameErrReg  <= ~rxS;
                  doneReg      <= 1'b1;
                  if (rxS) begin
                     state   <= IDLE;
                     busyReg <= 1'b0;
                  end else begin
                     state <= BREAK;
                  end
               end else begin
                  bitCount <= bitCount + 8'd1;
               end
            end
            BREAK: begin
               if (rxS) begin
                  state   <= IDLE;
                  busyReg <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               busyReg  <= 1'b0;
               bitCount <= 8'd0;
               bitIndex <= 3'd0;
            end
         endcase
      end
   end

   assign rxIf.o_bitsRx      = bitsReg;
   assign rxIf.o_doneRx      = doneReg;
   assign rxIf.o_parityErrRx = parityErrReg;
   assign rxIf.o_frameErrRx  = frameErrReg;
   assign rxIf.o_busyRx      = busyReg;

endmodule

// File: tb/tb_uart_rx_fpga.sv
// tb_uart_rx_fpga
// Purpose : drives serial frames into uart_rx_fpga at 234 clocks per bit and
//           compares the received byte, status flags, done timing and busy
//           behaviour against expectations worked out from the frame format.
// Ports   : none (top-level bench)
module tb_uart_rx_fpga;

   localparam int CPB = 234;
   // The pin is driven just after edge 0. Edges 1 and 2 move it through the
   // synchronizer, IDLE sees it at edge 3, and the stop sample that publishes
   // the byte comes 2457 edges after that.
   localparam int DONE_LAT = 3 + 2457;
   localparam int FRAME_LEN = 11 * CPB;

   typedef struct {
      int         cyc;
      logic [7:0] bits;
      logic       perr;
      logic       ferr;
   } doneRec_t;

   logic     clk = 1'b0;
   logic     reset = 1'b1;
   int       cycle = 0;
   int       errors = 0;
   int       checks = 0;
   doneRec_t doneQ[$];

   uart_rx_fpga_if rxIf ();

   uart_rx_fpga #(.clksPerBit(CPB)) dut (
      .i_clkRx (clk),
      .i_reset (reset),
      .rxIf    (rxIf)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Edge counter used to timestamp done pulses.
   always @(posedge clk) cycle <= cycle + 1;

   // Record every cycle in which done is high, on the falling edge.
   always @(negedge clk) begin
      if (rxIf.o_doneRx === 1'b1) begin
         doneQ.push_back('{cycle, rxIf.o_bitsRx, rxIf.o_parityErrRx, rxIf.o_frameErrRx});
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic driveBit(input logic b);
      rxIf.i_dataRx = b;
      tick(CPB);
   endtask

   // Sends one frame; the line is left at the stop-bit level afterwards.
   task automatic sendFrame(input logic [7:0] d, input logic par, input logic stp,
                            output int startCyc);
      startCyc = cycle;
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) driveBit(d[i]);
      driveBit(par);
      driveBit(stp);
   endtask

   function automatic logic evenPar(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return logic'(ones % 2);
   endfunction

   task automatic test_reset;
      rxIf.i_dataRx = 1'b1;
      reset = 1'b1;
      tick(3);
      checks++; if (rxIf.o_bitsRx !== 8'h00) begin errors++; $display("[TB] FAIL reset_bits: got %h expected 00", rxIf.o_bitsRx); end
      checks++; if (rxIf.o_doneRx !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", rxIf.o_doneRx); end
      checks++; if (rxIf.o_parityErrRx !== 1'b0) begin errors++; $display("[TB] FAIL reset_perr: got %b expected 0", rxIf.o_parityErrRx); end
      checks++; if (rxIf.o_frameErrRx !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b expected 0", rxIf.o_frameErrRx); end
      checks++; if (rxIf.o_busyRx !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", rxIf.o_busyRx); end
      reset = 1'b0;
      tick(10);
      checks++; if (rxIf.o_busyRx !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b expected 0", rxIf.o_busyRx); end
   endtask

   task automatic test_clean;
      int s;
      doneQ.delete();
      sendFrame(8'hA5, 1'b0, 1'b1, s);
      rxIf.i_dataRx = 1'b1;
      tick(30);
      checks++; if (doneQ.size() !== 1) begin errors++; $display("[TB] FAIL clean_pulses: got %0d expected 1", doneQ.size()); end
      if (doneQ.size() > 0) begin
         checks++; if (doneQ[0].cyc !== s + DONE_LAT) begin errors++; $display("[TB] FAIL clean_latency: got %0d expected %0d", doneQ[0].cyc - s, DONE_LAT); end
         checks++; if (doneQ[0].bits !== 8'hA5) begin errors++; $display("[TB] FAIL clean_bits: got %h expected a5", doneQ[0].bits); end
         checks++; if (doneQ[0].perr !== 1'b0) begin errors++; $display("[TB] FAIL clean_perr: got %b expected 0", doneQ[0].perr); end
         checks++; if (doneQ[0].ferr !== 1'b0) begin errors++; $display("[TB] FAIL clean_ferr: got %b expected 0", doneQ[0].ferr); end
      end
      checks++; if (rxIf.o_busyRx !== 1'b0) begin errors++; $display("[TB] FAIL clean_busy_after: got %b expected 0", rxIf.o_busyRx); end
      checks++; if (rxIf.o_bitsRx !== 8'hA5) begin errors++; $display("[TB] FAIL clean_bits_held: got %h expected a5", rxIf.o_bitsRx); end
   endtask

   task automatic test_parity;
      int s;
      doneQ.delete();
      sendFrame(8'h01, 1'b0, 1'b1, s);
      rxIf.i_dataRx = 1'b1;
      tick(30);
      checks++; if (doneQ.size() !== 1) begin errors++; $display("[TB] FAIL perr_pulses: got %0d expected 1", doneQ.size()); end
      checks++; if (rxIf.o_bitsRx !== 8'h01) begin errors++; $display("[TB] FAIL perr_bits: got %h expected 01", rxIf.o_bitsRx); end
      checks++; if (rxIf.o_parityErrRx !== 1'b1) begin errors++; $display("[TB] FAIL perr_flag: got %b expected 1", rxIf.o_parityErrRx); end
      checks++; if (rxIf.o_frameErrRx !== 1'b0) begin errors++; $display("[TB] FAIL perr_ferr: got %b expected 0", rxIf.o_frameErrRx); end
      doneQ.delete();
      sendFrame(8'h03, 1'b0, 1'b1, s);
      rxIf.i_dataRx = 1'b1;
      tick(30);
      checks++; if (doneQ.size() !== 1) begin errors++; $display("[TB] FAIL perr_clear_pulses: got %0d expected 1", doneQ.size()); end
      checks++; if (rxIf.o_bitsRx !== 8'h03) begin errors++; $display("[TB] FAIL perr_clear_bits: got %h expected 03", rxIf.o_bitsRx); end
      checks++; if (rxIf.o_parityErrRx !== 1'b0) begin errors++; $display("[TB] FAIL perr_clear_flag: got %b expected 0", rxIf.o_parityErrRx); end
   endtask

   task automatic test_glitch;
      logic busyAt[0:200];
      doneQ.delete();
      rxIf.i_dataRx = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         tick(1);
         busyAt[n] = rxIf.o_busyRx;
         if (n == 50) rxIf.i_dataRx = 1'b1;
      end
      checks++; if (busyAt[2] !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_before: got %b expected 0", busyAt[2]); end
      checks++; if (busyAt[3] !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_start: got %b expected 1", busyAt[3]); end
      checks++; if (busyAt[119] !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_hold: got %b expected 1", busyAt[119]); end
      checks++; if (busyAt[120] !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_drop: got %b expected 0", busyAt[120]); end
      checks++; if (doneQ.size() !== 0) begin errors++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", doneQ.size()); end
      checks++; if (rxIf.o_bitsRx !== 8'h03) begin errors++; $display("[TB] FAIL glitch_bits_kept: got %h expected 03", rxIf.o_bitsRx); end
   endtask

   task automatic test_break;
      int s;
      doneQ.delete();
      sendFrame(8'h3C, evenPar(8'h3C), 1'b0, s);
      tick(3000);
      checks++; if (doneQ.size() !== 1) begin errors++; $display("[TB] FAIL break_pulses: got %0d expected 1", doneQ.size()); end
      if (doneQ.size() > 0) begin
         checks++; if (doneQ[0].bits !== 8'h3C) begin errors++; $display("[TB] FAIL break_bits: got %h expected 3c", doneQ[0].bits); end
         checks++; if (doneQ[0].ferr !== 1'b1) begin errors++; $display("[TB] FAIL break_ferr: got %b expected 1", doneQ[0].ferr); end
         checks++; if (doneQ[0].perr !== 1'b0) begin errors++; $display("[TB] FAIL break_perr: got %b expected 0", doneQ[0].perr); end
      end
      checks++; if (rxIf.o_busyRx !== 1'b1) begin errors++; $display("[TB] FAIL break_busy_low_line: got %b expected 1", rxIf.o_busyRx); end
      rxIf.i_dataRx = 1'b1;
      tick(10);
      checks++; if (rxIf.o_busyRx !== 1'b0) begin errors++; $display("[TB] FAIL break_busy_release: got %b expected 0", rxIf.o_busyRx); end
      doneQ.delete();
      sendFrame(8'h7E, evenPar(8'h7E), 1'b1, s);
      rxIf.i_dataRx = 1'b1;
      tick(30);
      checks++; if (doneQ.size() !== 1) begin errors++; $display("[TB] FAIL break_next_pulses: got %0d expected 1", doneQ.size()); end
      checks++; if (rxIf.o_bitsRx !== 8'h7E) begin errors++; $display("[TB] FAIL break_next_bits: got %h expected 7e", rxIf.o_bitsRx); end
      checks++; if (rxIf.o_frameErrRx !== 1'b0) begin errors++; $display("[TB] FAIL break_next_ferr: got %b expected 0", rxIf.o_frameErrRx); end
      checks++; if (rxIf.o_parityErrRx !== 1'b0) begin errors++; $display("[TB] FAIL break_next_perr: got %b expected 0", rxIf.o_parityErrRx); end
   endtask

   task automatic test_back_to_back;
      int s0;
      int s1;
      doneQ.delete();
      sendFrame(8'h55, evenPar(8'h55), 1'b1, s0);
      sendFrame(8'hAA, evenPar(8'hAA), 1'b1, s1);
      rxIf.i_dataRx = 1'b1;
      tick(30);
      checks++; if (doneQ.size() !== 2) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", doneQ.size()); end
      if (doneQ.size() == 2) begin
         checks++; if (doneQ[1].cyc - doneQ[0].cyc !== FRAME_LEN) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d expected %0d", doneQ[1].cyc - doneQ[0].cyc, FRAME_LEN); end
         checks++; if (doneQ[0].bits !== 8'h55) begin errors++; $display("[TB] FAIL b2b_bits0: got %h expected 55", doneQ[0].bits); end
         checks++; if (doneQ[1].bits !== 8'hAA) begin errors++; $display("[TB] FAIL b2b_bits1: got %h expected aa", doneQ[1].bits); end
         checks++; if ({doneQ[0].perr, doneQ[0].ferr, doneQ[1].perr, doneQ[1].ferr} !== 4'b0000) begin errors++; $display("[TB] FAIL b2b_flags: got %b%b%b%b expected 0000", doneQ[0].perr, doneQ[0].ferr, doneQ[1].perr, doneQ[1].ferr); end
      end
   endtask

   task automatic test_reset_midframe;
      int s;
      logic [7:0] d;
      d = 8'hC3;
      doneQ.delete();
      driveBit(1'b0);
      for (int i = 0; i < 4; i++) driveBit(d[i]);
      rxIf.i_dataRx = d[4];
      tick(CPB / 2);
      reset = 1'b1;
      #1;
      checks++; if (rxIf.o_bitsRx !== 8'h00) begin errors++; $display("[TB] FAIL midrst_bits: got %h expected 00", rxIf.o_bitsRx); end
      checks++; if (rxIf.o_busyRx !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", rxIf.o_busyRx); end
      checks++; if ({rxIf.o_doneRx, rxIf.o_parityErrRx, rxIf.o_frameErrRx} !== 3'b000) begin errors++; $display("[TB] FAIL midrst_flags: got %b%b%b expected 000", rxIf.o_doneRx, rxIf.o_parityErrRx, rxIf.o_frameErrRx); end
      tick(3);
      rxIf.i_dataRx = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(CPB * 6);
      checks++; if (doneQ.size() !== 0) begin errors++; $display("[TB] FAIL midrst_pulses: got %0d expected 0", doneQ.size()); end
      sendFrame(d, evenPar(d), 1'b1, s);
      rxIf.i_dataRx = 1'b1;
      tick(30);
      checks++; if (doneQ.size() !== 1) begin errors++; $display("[TB] FAIL midrst_next_pulses: got %0d expected 1", doneQ.size()); end
      checks++; if (rxIf.o_bitsRx !== 8'hC3) begin errors++; $display("[TB] FAIL midrst_next_bits: got %h expected c3", rxIf.o_bitsRx); end
      checks++; if ({rxIf.o_parityErrRx, rxIf.o_frameErrRx} !== 2'b00) begin errors++; $display("[TB] FAIL midrst_next_flags: got %b%b expected 00", rxIf.o_parityErrRx, rxIf.o_frameErrRx); end
   endtask

   task automatic test_random;
      int s;
      logic [7:0] d;
      logic par;
      logic stp;
      logic expPerr;
      for (int k = 0; k < 4; k++) begin
         d = 8'($urandom_range(0, 255));
         par = evenPar(d) ^ logic'($urandom_range(0, 1));
         stp = ($urandom_range(0, 3) != 0);
         expPerr = (par != evenPar(d));
         doneQ.delete();
         sendFrame(d, par, stp, s);
         rxIf.i_dataRx = 1'b1;
         tick(30);
         checks++; if (doneQ.size() !== 1) begin errors++; $display("[TB] FAIL rand%0d_pulses: got %0d expected 1", k, doneQ.size()); end
         if (doneQ.size() > 0) begin
            checks++; if (doneQ[0].cyc !== s + DONE_LAT) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", k, doneQ[0].cyc - s, DONE_LAT); end
            checks++; if (doneQ[0].bits !== d) begin errors++; $display("[TB] FAIL rand%0d_bits: got %h expected %h", k, doneQ[0].bits, d); end
            checks++; if (doneQ[0].perr !== expPerr) begin errors++; $display("[TB] FAIL rand%0d_perr: got %b expected %b", k, doneQ[0].perr, expPerr); end
            checks++; if (doneQ[0].ferr !== !stp) begin errors++; $display("[TB] FAIL rand%0d_ferr: got %b expected %b", k, doneQ[0].ferr, !stp); end
         end
         checks++; if (rxIf.o_busyRx !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_busy: got %b expected 0", k, rxIf.o_busyRx); end
      end
   endtask

   // Scenario sequence.
   initial begin
      rxIf.i_dataRx = 1'b1;
      test_reset();
      test_clean();
      test_parity();
      test_glitch();
      test_break();
      test_back_to_back();
      test_reset_midframe();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
